// File: rtl/coffee_sequencer.sv
// Brew controller: latches a drink, waits for payment, checks supplies, then runs timed
// water/mix/dispense phases. Define COFFEE_SEQ_PAY_TIMEOUT_EN to abort SELECT with ERDI.
module coffee_sequencer #(
  parameter int unsigned TICK_DIV    = 5_000_000,
  parameter int unsigned T_WATER     = 30,
  parameter int unsigned T_MIX       = 20,
  parameter int unsigned T_DISP      = 10,
  parameter int unsigned PAY_TIMEOUT = 100,
  parameter int unsigned ERR_HOLD    = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       SR,
  input  logic       SP,
  input  logic       SN,
  input  logic       VL,
  input  logic       M,
  output logic [3:0] msg,
  output logic       valve_water,
  output logic       mixer,
  output logic       dispense,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxA     = (4 * T_WATER > PAY_TIMEOUT) ? 4 * T_WATER : PAY_TIMEOUT;
  localparam int unsigned MaxB     = (MaxA > ERR_HOLD) ? MaxA : ERR_HOLD;
  localparam int unsigned MaxC     = (MaxB > T_MIX) ? MaxB : T_MIX;
  localparam int unsigned MaxTicks = (MaxC > T_DISP) ? MaxC : T_DISP;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned PresW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0] MsgWait  = 4'd0;
  localparam logic [3:0] MsgErsr  = 4'd5;
  localparam logic [3:0] MsgErsp  = 4'd6;
  localparam logic [3:0] MsgErsn  = 4'd7;
`ifdef COFFEE_SEQ_PAY_TIMEOUT_EN
  localparam logic [3:0] MsgErdi  = 4'd8;
`endif
  localparam logic [3:0] MsgMaint = 4'd9;

  typedef enum logic [3:0] {
    StIdle,
    StSelect,
    StCheck,
    StWater,
    StMix,
    StDispense,
    StDone,
    StError,
    StMaint
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         drink_q, drink_d;
  logic [3:0]         err_q, err_d;
  logic [3:0]         msg_d;
  logic [PresW-1:0]   presc_q;
  logic [CntW-1:0]    cnt_q;
  logic [1:0]         btn_idx;
  logic [31:0]        phase_len;
  logic               tick;
  logic               phase_end;

  always_comb begin
    if (S0)      btn_idx = 2'd0;
    else if (S1) btn_idx = 2'd1;
    else if (S2) btn_idx = 2'd2;
    else         btn_idx = 2'd3;
  end

  // Length in ticks of the timed phase currently active; 0 means untimed.
  always_comb begin
    phase_len = 32'd0;
    unique case (state_q)
      StSelect:   phase_len = PAY_TIMEOUT;
      StWater:    phase_len = (32'(drink_q) + 32'd1) * T_WATER;
      StMix:      phase_len = T_MIX;
      StDispense: phase_len = T_DISP;
      StError:    phase_len = ERR_HOLD;
      default:    phase_len = 32'd0;
    endcase
  end

  assign tick      = (presc_q == PresW'(TICK_DIV - 1));
  assign phase_end = tick && (phase_len != 32'd0) && (32'(cnt_q) == phase_len - 32'd1);

  always_comb begin
    state_d = state_q;
    drink_d = drink_q;
    err_d   = err_q;
    if (M) begin
      state_d = StMaint;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (S0 || S1 || S2 || S3) begin
            state_d = StSelect;
            drink_d = btn_idx;
          end
        end
        StSelect: begin
          if (VL) begin
            state_d = StCheck;
          end
`ifdef COFFEE_SEQ_PAY_TIMEOUT_EN
          else if (phase_end) begin
            state_d = StError;
            err_d   = MsgErdi;
          end
`endif
        end
        StCheck: begin
          if (!SR) begin
            state_d = StError;
            err_d   = MsgErsr;
          end else if (!SP) begin
            state_d = StError;
            err_d   = MsgErsp;
          end else if (!SN) begin
            state_d = StError;
            err_d   = MsgErsn;
          end else begin
            state_d = StWater;
          end
        end
        StWater: begin
          // Losing the reservoir aborts immediately, even on the final tick.
          if (!SR) begin
            state_d = StError;
            err_d   = MsgErsr;
          end else if (phase_end) begin
            state_d = (drink_q >= 2'd2) ? StMix : StDispense;
          end
        end
        StMix: begin
          if (phase_end) state_d = StDispense;
        end
        StDispense: begin
          if (phase_end) state_d = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
        StError: begin
          if (phase_end) state_d = StIdle;
        end
        StMaint: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    msg_d = MsgWait;
    unique case (state_d)
      StIdle:  msg_d = MsgWait;
      StError: msg_d = err_d;
      StMaint: msg_d = MsgMaint;
      default: msg_d = {2'b00, drink_d} + 4'd1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      drink_q     <= 2'd0;
      err_q       <= 4'd0;
      presc_q     <= '0;
      cnt_q       <= '0;
      msg         <= MsgWait;
      valve_water <= 1'b0;
      mixer       <= 1'b0;
      dispense    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      drink_q <= drink_d;
      err_q   <= err_d;
      // Both counters restart on every state entry so phases are exact multiples of a tick.
      if (state_d != state_q) begin
        presc_q <= '0;
        cnt_q   <= '0;
      end else if (tick) begin
        presc_q <= '0;
        if (cnt_q != {CntW{1'b1}}) cnt_q <= cnt_q + CntW'(1);
      end else begin
        presc_q <= presc_q + PresW'(1);
      end
      msg         <= msg_d;
      valve_water <= (state_d == StWater);
      mixer       <= (state_d == StMix);
      dispense    <= (state_d == StDispense);
      busy        <= (state_d != StIdle) && (state_d != StMaint);
      done        <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_coffee_sequencer.sv
// Bench for coffee_sequencer: cycle-counted phase model checked every cycle, plus literal
// expectations for each scenario. Honours COFFEE_SEQ_PAY_TIMEOUT_EN like the design.
module tb_coffee_sequencer;

  localparam int TD  = 4;
  localparam int TW  = 3;
  localparam int TM  = 2;
  localparam int TDS = 2;
  localparam int PT  = 5;
  localparam int EH  = 2;
`ifdef COFFEE_SEQ_PAY_TIMEOUT_EN
  localparam bit PayEn = 1'b1;
`else
  localparam bit PayEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
  logic       SR = 1'b1, SP = 1'b1, SN = 1'b1;
  logic       VL = 1'b0, M = 1'b0;
  logic [3:0] msg;
  logic       valve_water, mixer, dispense, busy, done;

  int errors = 0;
  int checks = 0;
  int n_msg[16];
  int n_valve, n_mix, n_disp, n_done;

  coffee_sequencer #(
    .TICK_DIV   (TD),
    .T_WATER    (TW),
    .T_MIX      (TM),
    .T_DISP     (TDS),
    .PAY_TIMEOUT(PT),
    .ERR_HOLD   (EH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .S0         (S0),
    .S1         (S1),
    .S2         (S2),
    .S3         (S3),
    .SR         (SR),
    .SP         (SP),
    .SN         (SN),
    .VL         (VL),
    .M          (M),
    .msg        (msg),
    .valve_water(valve_water),
    .mixer      (mixer),
    .dispense   (dispense),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  // Model: phase plus cycles remaining in it, counted in whole clock cycles.
  typedef enum {PIdle, PSel, PChk, PWater, PMix, PDisp, PDone, PErr, PMaint} ph_t;
  ph_t        ph = PIdle;
  int         left = 0;
  int         d = 0;
  logic [3:0] err = 4'd0;

  task automatic go(input ph_t p, input int ticks);
    ph   = p;
    left = ticks * TD;
  endtask

  task automatic fault(input logic [3:0] code);
    err = code;
    go(PErr, EH);
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      ph = PIdle; d = 0; err = 4'd0; left = 0;
    end else if (M) begin
      ph = PMaint;
    end else begin
      case (ph)
        PIdle: if (S0 || S1 || S2 || S3) begin
          d = S0 ? 0 : S1 ? 1 : S2 ? 2 : 3;
          go(PSel, PT);
        end
        PSel: if (VL) go(PChk, 0);
              else if (PayEn) begin
                left--;
                if (left == 0) fault(4'd8);
              end
        PChk: if (!SR) fault(4'd5);
              else if (!SP) fault(4'd6);
              else if (!SN) fault(4'd7);
              else go(PWater, (d + 1) * TW);
        PWater: if (!SR) fault(4'd5);
                else begin
                  left--;
                  if (left == 0) begin
                    if (d >= 2) go(PMix, TM);
                    else go(PDisp, TDS);
                  end
                end
        PMix: begin
          left--;
          if (left == 0) go(PDisp, TDS);
        end
        PDisp: begin
          left--;
          if (left == 0) go(PDone, 0);
        end
        PDone: ph = PIdle;
        PErr: begin
          left--;
          if (left == 0) ph = PIdle;
        end
        PMaint: ph = PIdle;
        default: ph = PIdle;
      endcase
    end
  end

  function automatic logic [8:0] model_vec();
    logic [3:0] m;
    case (ph)
      PIdle:   m = 4'd0;
      PErr:    m = err;
      PMaint:  m = 4'd9;
      default: m = 4'(d + 1);
    endcase
    return {m, ph == PWater, ph == PMix, ph == PDisp, !(ph == PIdle || ph == PMaint),
            ph == PDone};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {msg, valve_water, mixer, dispense, busy, done};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clr();
    foreach (n_msg[i]) n_msg[i] = 0;
    n_valve = 0; n_mix = 0; n_disp = 0; n_done = 0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
    check("cycle {msg,valve,mixer,disp,busy,done}", 16'(dut_vec()), 16'(model_vec()));
    if (!$isunknown(msg)) n_msg[msg]++;
    n_valve += int'(valve_water === 1'b1);
    n_mix   += int'(mixer === 1'b1);
    n_disp  += int'(dispense === 1'b1);
    n_done  += int'(done === 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    clr();
    // Reset
    run(3);
    check("reset outputs", 16'(dut_vec()), 16'd0);
    RST = 1'b0;
    run(2);

    // CL02 brew
    clr();
    S1 = 1'b1; cyc(); S1 = 1'b0;
    check("cl02 msg after button", 16'(msg), 16'd2);
    VL = 1'b1; cyc(); VL = 1'b0;
    run(60);
    check("cl02 valve cycles", 16'(n_valve), 16'd24);
    check("cl02 mixer cycles", 16'(n_mix), 16'd0);
    check("cl02 dispense cycles", 16'(n_disp), 16'd8);
    check("cl02 done pulses", 16'(n_done), 16'd1);
    check("cl02 msg2 cycles", 16'(n_msg[2]), 16'd35);
    check("cl02 final msg", 16'(msg), 16'd0);

    // CP10 brew, S2+S3 together -> S2 wins
    clr();
    S2 = 1'b1; S3 = 1'b1; cyc(); S2 = 1'b0; S3 = 1'b0;
    check("cc05 priority msg", 16'(msg), 16'd3);
    VL = 1'b1; cyc(); VL = 1'b0;
    run(60);
    check("cc05 valve cycles", 16'(n_valve), 16'd36);
    check("cc05 mixer cycles", 16'(n_mix), 16'd8);
    check("cc05 dispense cycles", 16'(n_disp), 16'd8);
    check("cc05 done pulses", 16'(n_done), 16'd1);

    // Sensor failures
    clr();
    SR = 1'b0;
    S0 = 1'b1; cyc(); S0 = 1'b0;
    VL = 1'b1; cyc(); VL = 1'b0;
    run(12);
    SR = 1'b1;
    check("ersr msg5 cycles", 16'(n_msg[5]), 16'd8);
    check("ersr actuators", 16'(n_valve + n_mix + n_disp), 16'd0);
    check("ersr back to wait", 16'(msg), 16'd0);
    clr();
    SP = 1'b0; SN = 1'b0;
    S0 = 1'b1; cyc(); S0 = 1'b0;
    VL = 1'b1; cyc(); VL = 1'b0;
    cyc();
    check("ersp priority msg", 16'(msg), 16'd6);
    run(10);
    SP = 1'b1; SN = 1'b1;
    check("ersp msg6 cycles", 16'(n_msg[6]), 16'd8);

    // Payment timeout
    clr();
    S0 = 1'b1; cyc(); S0 = 1'b0;
`ifdef COFFEE_SEQ_PAY_TIMEOUT_EN
    run(30);
    check("timeout select cycles", 16'(n_msg[1]), 16'd20);
    check("timeout erdi cycles", 16'(n_msg[8]), 16'd8);
`else
    run(1000);
    check("no-timeout select cycles", 16'(n_msg[1]), 16'd1001);
    check("no-timeout erdi cycles", 16'(n_msg[8]), 16'd0);
    M = 1'b1; cyc(); M = 1'b0;
    check("maint exits select", 16'(msg), 16'd9);
    cyc();
    check("idle after maint", 16'(msg), 16'd0);
`endif

    // SR drop mid-WATER
    clr();
    S0 = 1'b1; cyc(); S0 = 1'b0;
    VL = 1'b1; cyc(); VL = 1'b0;
    run(5);
    SR = 1'b0; cyc();
    check("sr drop valve", 16'(valve_water), 16'd0);
    check("sr drop msg", 16'(msg), 16'd5);
    check("sr drop valve cycles", 16'(n_valve), 16'd5);
    SR = 1'b1;
    run(10);

    // M mid-MIX
    clr();
    S2 = 1'b1; cyc(); S2 = 1'b0;
    VL = 1'b1; cyc(); VL = 1'b0;
    run(39);
    check("in mix before M", 16'(mixer), 16'd1);
    M = 1'b1; cyc();
    check("maint mixer off", 16'(mixer), 16'd0);
    check("maint msg", 16'(msg), 16'd9);
    check("maint busy", 16'(busy), 16'd0);
    run(3);
    M = 1'b0; cyc();
    check("idle after maint release", 16'({msg, busy}), 16'd0);

    // RST mid-DISPENSE
    clr();
    S0 = 1'b1; cyc(); S0 = 1'b0;
    VL = 1'b1; cyc(); VL = 1'b0;
    run(15);
    check("in dispense before RST", 16'(dispense), 16'd1);
    RST = 1'b1; cyc();
    check("rst mid-dispense outputs", 16'(dut_vec()), 16'd0);
    RST = 1'b0; cyc();
    check("idle after rst", 16'(dut_vec()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
